// File: rtl/cbc_stream_controller.sv
// CBC-mode stream encryption controller around a single shared PRESENT-style block core.
// One plaintext beat per cycle in, one ciphertext beat per cycle out, chain re-armed to IV per message.

// Reduced PRESENT-style block cipher: 16-bit block, 20-bit key, 8 rounds, purely combinational.
module present_encipher (
   input  logic [15:0] data,
   input  logic [19:0] key,
   output logic [15:0] result_c
);

   localparam int unsigned ROUNDS = 8;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
         4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
         4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
         4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
      endcase
   endfunction

   logic [15:0] st;
   logic [15:0] sub;
   logic [15:0] perm;
   logic [19:0] rk;

   // Each round: add round key (top 16 key bits), nibble S-box, bit permutation, key update.
   always_comb begin
      st   = data;
      rk   = key;
      sub  = '0;
      perm = '0;
      for (int r = 1; r <= ROUNDS; r++) begin
         st = st ^ rk[19:4];
         for (int n = 0; n < 4; n++) begin
            sub[4*n +: 4] = sbox(st[4*n +: 4]);
         end
         for (int i = 0; i < 15; i++) begin
            perm[4'((i * 4) % 15)] = sub[4'(i)];
         end
         perm[15] = sub[15];
         st = perm;
         rk = {rk[6:0], rk[19:7]};
         rk[19:16] = sbox(rk[19:16]);
         rk[4:0] = rk[4:0] ^ 5'(r);
      end
      result_c = st ^ rk[19:4];
   end

endmodule

module cbc_stream_controller #(
   parameter int unsigned BLOCK_W = 16,
   parameter int unsigned KEY_W   = 20,
   parameter int unsigned CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_load,
   input  logic [BLOCK_W-1:0] iv_in,
   input  logic [KEY_W-1:0]   key_in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BLOCK_W-1:0] in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_data,
   output logic               out_last,
   output logic               busy,
   output logic [CNT_W-1:0]   blk_count,
   output logic               err_cfg
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] FLUSH  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]         state, state_nx;
   logic [BLOCK_W-1:0] iv_reg, iv_nx;
   logic [KEY_W-1:0]   key_reg, key_nx;
   logic [BLOCK_W-1:0] chain, chain_nx;
   logic [BLOCK_W-1:0] out_data_nx;
   logic               out_last_nx;
   logic               out_valid_nx;
   logic [CNT_W-1:0]   blk_nx;
   logic               err_nx;
   logic               cfg_take_c;
   logic               accept_c;
   logic [BLOCK_W-1:0] core_in_c;
   logic [BLOCK_W-1:0] cipher_c;

   assign core_in_c = chain ^ in_data;

   present_encipher u_core (
      .data     (core_in_c),
      .key      (key_reg),
      .result_c (cipher_c)
   );

   // State register and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         iv_reg    <= '0;
         key_reg   <= '0;
         chain     <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
         blk_count <= '0;
         err_cfg   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         iv_reg    <= iv_nx;
         key_reg   <= key_nx;
         chain     <= chain_nx;
         out_data  <= out_data_nx;
         out_last  <= out_last_nx;
         out_valid <= out_valid_nx;
         blk_count <= blk_nx;
         err_cfg   <= err_nx;
         busy      <= (state_nx != IDLE);
      end
   end

   // Next-state, handshake and datapath update.
   always_comb begin
      state_nx     = state;
      iv_nx        = iv_reg;
      key_nx       = key_reg;
      chain_nx     = chain;
      out_data_nx  = out_data;
      out_last_nx  = out_last;
      out_valid_nx = out_valid;
      blk_nx       = blk_count;
      err_nx       = err_cfg;

      // Configuration wins over a simultaneous plaintext beat in IDLE.
      cfg_take_c = (state == IDLE) && cfg_load;
      in_ready   = rst_n && (state != FLUSH) && !cfg_take_c && (!out_valid || out_ready);
      accept_c   = in_valid && in_ready;

      if (cfg_load && (state != IDLE)) begin
         err_nx = 1'b1;
      end

      if (cfg_take_c) begin
         iv_nx    = iv_in;
         key_nx   = key_in;
         chain_nx = iv_in;
      end

      if (accept_c) begin
         out_data_nx  = cipher_c;
         chain_nx     = cipher_c;
         out_last_nx  = in_last;
         out_valid_nx = 1'b1;
         if (state == IDLE) begin
            blk_nx = CNT_W'(1);
         end else if (blk_count != CNT_MAX) begin
            blk_nx = blk_count + CNT_W'(1);
         end
         if (in_last) begin
            state_nx = FLUSH;
         end else if (state == IDLE) begin
            state_nx = ACTIVE;
         end
      end else if (out_ready) begin
         out_valid_nx = 1'b0;
      end

      // Final ciphertext beat leaves: re-arm the chain for the next message.
      if ((state == FLUSH) && out_valid && out_ready && out_last) begin
         state_nx = IDLE;
         chain_nx = iv_reg;
      end
   end

endmodule

// File: tb/tb_cbc_stream_controller.sv
// Self-checking bench for cbc_stream_controller: directed vector table, corner-case sequences,
// and randomized traffic checked cycle by cycle against a transaction-level CBC model.
module tb_cbc_stream_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_load;
   logic [15:0] iv_in;
   logic [19:0] key_in;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic        busy;
   logic [7:0]  blk_count;
   logic        err_cfg;

   always #5 clk = ~clk;

   cbc_stream_controller #(.BLOCK_W(16), .KEY_W(20), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .iv_in(iv_in), .key_in(key_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .blk_count(blk_count), .err_cfg(err_cfg)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Golden block cipher written from its round description.
   int unsigned sbox_t [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

   function automatic logic [15:0] enc(input logic [15:0] pt, input logic [19:0] key);
      logic [15:0] s, u, t;
      logic [19:0] k;
      logic [39:0] kk;
      int dst;
      s = pt;
      k = key;
      for (int r = 1; r <= 8; r++) begin
         s = s ^ k[19:4];
         for (int n = 0; n < 4; n++) u[n*4 +: 4] = 4'(sbox_t[s[n*4 +: 4]]);
         t = '0;
         for (int b = 0; b < 16; b++) begin
            dst = (b == 15) ? 15 : (b * 4) % 15;
            t[4'(dst)] = u[4'(b)];
         end
         s = t;
         kk = {k, k};
         k = kk[26:7];
         k[19:16] = 4'(sbox_t[k[19:16]]);
         k[4:0] = k[4:0] ^ 5'(r);
      end
      return s ^ k[19:4];
   endfunction

   // Transaction-level model: message framing flags, shadow regs, and an expected-output queue.
   typedef struct packed { logic [15:0] data; logic last; } beat_t;
   beat_t       q[$];
   bit          m_known = 0;
   bit          m_in_msg, m_last_taken, m_err;
   logic [15:0] m_iv, m_chain;
   logic [19:0] m_key;
   int          m_cnt;

   always @(negedge clk) begin
      bit          exp_ready, pre_msg, hs, acc;
      beat_t       b;
      logic [15:0] c;
      exp_ready = rst_n && m_known && !m_last_taken && !(!m_in_msg && cfg_load) &&
                  (q.size() == 0 || out_ready);
      if (!rst_n) begin
         chk("mon_in_ready_rst", 32'(in_ready), 0);
         q.delete();
         m_in_msg = 0; m_last_taken = 0; m_err = 0;
         m_iv = '0; m_key = '0; m_chain = '0; m_cnt = 0;
         m_known = 1;
      end else if (m_known) begin
         chk("mon_in_ready", 32'(in_ready), 32'(exp_ready));
         chk("mon_out_valid", 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            chk("mon_out_data", 32'(out_data), 32'(q[0].data));
            chk("mon_out_last", 32'(out_last), 32'(q[0].last));
         end
         chk("mon_busy", 32'(busy), 32'(m_in_msg));
         chk("mon_blk_count", 32'(blk_count), 32'(m_cnt));
         chk("mon_err_cfg", 32'(err_cfg), 32'(m_err));

         pre_msg = m_in_msg;
         hs  = (q.size() != 0) && out_ready;
         acc = in_valid && exp_ready;
         if (cfg_load) begin
            if (!pre_msg) begin
               m_iv = iv_in; m_key = key_in; m_chain = iv_in;
            end else begin
               m_err = 1;
            end
         end
         if (hs) begin
            b = q.pop_front();
            if (b.last) begin
               m_in_msg = 0; m_last_taken = 0; m_chain = m_iv;
            end
         end
         if (acc) begin
            c = enc(m_chain ^ in_data, m_key);
            m_chain = c;
            q.push_back({c, in_last});
            m_cnt = !pre_msg ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
            m_in_msg = 1;
            if (in_last) m_last_taken = 1;
         end
      end
   end

   // Present one beat and wait (bounded) for it to be accepted; got = ciphertext after the edge.
   task automatic send(input logic [15:0] d, input logic last, output logic [15:0] got);
      bit ok;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      ok = 0;
      for (int w = 0; w < 64 && !ok; w++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: actual=not_accepted required=accepted (cycle %0d)", cyc);
      end
      got = out_data;
   endtask

   task automatic do_cfg(input logic [15:0] iv, input logic [19:0] key);
      cfg_load = 1'b1;
      iv_in    = iv;
      key_in   = key;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
   endtask

   typedef struct { logic [15:0] pt; logic last; logic [15:0] ct; logic ct_last; } vec_t;
   vec_t tbl [8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] got, ch, pt, g;
      logic [15:0] p [5];
      logic [15:0] gl [5];
      logic [15:0] cap [2][3];
      int t0;

      rst_n = 1'b0; cfg_load = 1'b0; iv_in = '0; key_in = '0;
      in_valid = 1'b1; in_data = 16'h1111; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_blk_count", 32'(blk_count), 0);
      chk("rst_err_cfg", 32'(err_cfg), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_data", 32'(out_data), 0);
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;

      // Eight-block message against the precomputed vector table.
      do_cfg(16'hA5A5, 20'h12345);
      ch = 16'hA5A5;
      for (int i = 0; i < 8; i++) begin
         tbl[i].pt      = 16'($urandom);
         tbl[i].last    = (i == 7);
         tbl[i].ct      = enc(ch ^ tbl[i].pt, 20'h12345);
         tbl[i].ct_last = (i == 7);
         ch = tbl[i].ct;
      end
      t0 = cyc;
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].pt, tbl[i].last, got);
         chk("t2_data", 32'(got), 32'(tbl[i].ct));
         chk("t2_last", 32'(out_last), 32'(tbl[i].ct_last));
         chk("t2_valid", 32'(out_valid), 1);
      end
      chk("t2_throughput", 32'(cyc - t0), 8);
      chk("t2_blk_count", 32'(blk_count), 8);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("t2_busy_after", 32'(busy), 0);
      chk("t2_blk_hold", 32'(blk_count), 8);

      // Back-to-back 3-block messages with identical plaintext.
      for (int i = 0; i < 3; i++) p[i] = 16'($urandom);
      ch = 16'hA5A5;
      for (int i = 0; i < 3; i++) begin
         gl[i] = enc(ch ^ p[i], 20'h12345);
         ch = gl[i];
      end
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 3; i++) begin
            send(p[i], i == 2, got);
            cap[m][i] = got;
         end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 3; i++) chk("t3_msg_ct", 32'(cap[m][i]), 32'(gl[i]));

      // Backpressure: out_ready 1,0,0,1 mid-message.
      for (int i = 0; i < 4; i++) p[i] = 16'($urandom);
      ch = 16'hA5A5;
      for (int i = 0; i < 4; i++) begin
         gl[i] = enc(ch ^ p[i], 20'h12345);
         ch = gl[i];
      end
      send(p[0], 1'b0, got);
      chk("t4_ct0", 32'(got), 32'(gl[0]));
      out_ready = 1'b0;
      in_data = p[1];
      repeat (2) begin
         @(negedge clk);
         chk("t4_stall_in_ready", 32'(in_ready), 0);
         chk("t4_stall_data", 32'(out_data), 32'(gl[0]));
         chk("t4_stall_last", 32'(out_last), 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         send(p[i], i == 3, got);
         chk("t4_ct", 32'(got), 32'(gl[i]));
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("t4_drained", 32'(q.size()), 0);
      chk("t4_busy", 32'(busy), 0);

      // cfg_load while ACTIVE is ignored and flagged.
      for (int i = 0; i < 3; i++) p[i] = 16'($urandom);
      ch = 16'hA5A5;
      for (int i = 0; i < 3; i++) begin
         gl[i] = enc(ch ^ p[i], 20'h12345);
         ch = gl[i];
      end
      send(p[0], 1'b0, got);
      chk("t5_ct0", 32'(got), 32'(gl[0]));
      cfg_load = 1'b1; iv_in = 16'hFFFF; key_in = 20'hFFFFF;
      send(p[1], 1'b0, got);
      cfg_load = 1'b0;
      chk("t5_ct1", 32'(got), 32'(gl[1]));
      chk("t5_err", 32'(err_cfg), 1);
      send(p[2], 1'b1, got);
      chk("t5_ct2", 32'(got), 32'(gl[2]));
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("t5_err_sticky", 32'(err_cfg), 1);

      // cfg_load with a simultaneous beat in IDLE: beat waits; then a single-block message.
      pt = 16'($urandom);
      cfg_load = 1'b1; iv_in = 16'h1234; key_in = 20'h0BEEF;
      in_valid = 1'b1; in_data = pt; in_last = 1'b1;
      @(negedge clk);
      chk("t5_cfg_blocks_beat", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      chk("t5_no_accept", 32'(out_valid), 0);
      send(pt, 1'b1, got);
      chk("t5_single_ct", 32'(got), 32'(enc(16'h1234 ^ pt, 20'h0BEEF)));
      chk("t5_single_last", 32'(out_last), 1);
      chk("t5_single_cnt", 32'(blk_count), 1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_single_idle", 32'(busy), 0);

      // Reset after block 2 of 5, then a fresh message.
      do_cfg(16'hA5A5, 20'h12345);
      for (int i = 0; i < 5; i++) p[i] = 16'($urandom);
      send(p[0], 1'b0, got);
      send(p[1], 1'b0, got);
      in_data = p[2];
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t6_no_output", 32'(out_valid), 0);
         @(posedge clk);
         #1;
      end
      chk("t6_err_cleared", 32'(err_cfg), 0);
      chk("t6_cnt_cleared", 32'(blk_count), 0);
      do_cfg(16'h0F0F, 20'hABCDE);
      ch = 16'h0F0F;
      for (int i = 0; i < 3; i++) begin
         g = enc(ch ^ p[i], 20'hABCDE);
         ch = g;
         send(p[i], i == 2, got);
         chk("t6_fresh_ct", 32'(got), 32'(g));
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Long message: block counter saturates.
      for (int i = 0; i < 257; i++) send(16'($urandom), i == 256, got);
      chk("t7_saturate", 32'(blk_count), 255);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Randomized traffic, checked by the monitor model.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         rst_n     = ($urandom % 600) != 0;
         in_valid  = ($urandom % 4) != 0;
         in_data   = 16'($urandom);
         in_last   = ($urandom % 5) == 0;
         out_ready = ($urandom % 3) != 0;
         cfg_load  = ($urandom % 16) == 0;
         iv_in     = 16'($urandom);
         key_in    = 20'($urandom);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1; in_valid = 1'b0; cfg_load = 1'b0; out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("rand_drained", 32'(q.size()), 0);
      chk("rand_idle_valid", 32'(out_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
